// File: rtl/neuron_scheduler_pkg.sv
// Shared types, defaults and helpers for the neuron scheduler and its datapath.
package neuron_scheduler_pkg;

   localparam int NEURONS_D   = 10;
   localparam int CHUNKS_D    = 4;
   localparam int BUS_WIDTH_D = 196;
   localparam int DRAIN_D     = 12;
   localparam int VAL_SIZE_D  = 26;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      RUN,
      ACC,
      CMP,
      DONE
   } state_t;

   // Ceiling log2, never narrower than one bit so index ports stay legal.
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r = r + 1;
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/neuron_scheduler_argmax_tracker.sv
// Running argmax over neuron scores; strict compare keeps the lowest index on ties.
module argmax_tracker
   import neuron_scheduler_pkg::*;
#(
   parameter int NEURONS  = NEURONS_D,
   parameter int ACC_SIZE = VAL_SIZE_D + 2,
   localparam int NW      = clog2(NEURONS)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                i_clear,
   input  logic                i_upd,
   input  logic [ACC_SIZE-1:0] i_acc,
   input  logic [NW-1:0]       i_idx,
   output logic [ACC_SIZE-1:0] o_best_nxt,
   output logic [NW-1:0]       o_class_nxt
);

   logic [ACC_SIZE-1:0] r_best;
   logic [NW-1:0]       r_class;
   logic                w_gt;

   always_comb begin
      w_gt        = $signed(i_acc) > $signed(r_best);
      o_best_nxt  = r_best;
      o_class_nxt = r_class;
      if (i_upd && w_gt) begin
         o_best_nxt  = i_acc;
         o_class_nxt = i_idx;
      end
   end

   // Most-negative seed so an all-negative image still picks a winner.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_best  <= '0;
         r_class <= '0;
      end else if (i_clear) begin
         r_best  <= {1'b1, {(ACC_SIZE-1){1'b0}}};
         r_class <= '0;
      end else if (i_upd) begin
         r_best  <= o_best_nxt;
         r_class <= o_class_nxt;
      end
   end

endmodule

// File: rtl/neuron_scheduler.sv
// Chunk/neuron sequencer with accumulate and argmax for one image classification.
// Optional per-neuron score stream: define NEURON_SCORE_STREAM_EN.
module neuron_scheduler
   import neuron_scheduler_pkg::*;
#(
   parameter int NEURONS   = NEURONS_D,
   parameter int CHUNKS    = CHUNKS_D,
   parameter int BUS_WIDTH = BUS_WIDTH_D,
   parameter int DRAIN     = DRAIN_D,
   parameter int VAL_SIZE  = VAL_SIZE_D,
   parameter int ACC_SIZE  = VAL_SIZE + 2,
   localparam int NW       = clog2(NEURONS),
   localparam int CW       = clog2(CHUNKS)
) (
   input  logic                clk,
   input  logic                GlobalReset,
   input  logic                start,
   input  logic                abort,
   input  logic [VAL_SIZE-1:0] dp_value,
   output logic                dp_clear,
   output logic [CW-1:0]       chunk_idx,
   output logic [NW-1:0]       neuron_idx,
   output logic                busy,
   output logic                done,
   output logic [NW-1:0]       class_out,
   output logic [ACC_SIZE-1:0] best_score
`ifdef NEURON_SCORE_STREAM_EN
   ,
   output logic                score_valid,
   output logic [ACC_SIZE-1:0] score,
   output logic [NW-1:0]       score_idx
`endif
);

   localparam int RUN_LEN = BUS_WIDTH + DRAIN;
   localparam int TW      = clog2(RUN_LEN);

   state_t              r_state;
   state_t              w_next;
   logic [TW-1:0]       r_cnt;
   logic [CW-1:0]       r_chunk;
   logic [NW-1:0]       r_neuron;
   logic [ACC_SIZE-1:0] r_acc;
   logic [NW-1:0]       r_class;
   logic [ACC_SIZE-1:0] r_best;
   logic                w_last_chunk;
   logic                w_last_neuron;
   logic                w_run_end;
   logic                w_abort;
   logic                w_accept;
   logic [ACC_SIZE-1:0] w_dp_ext;
   logic [ACC_SIZE-1:0] w_best_nxt;
   logic [NW-1:0]       w_class_nxt;

   assign w_last_chunk  = (r_chunk == CW'(CHUNKS - 1));
   assign w_last_neuron = (r_neuron == NW'(NEURONS - 1));
   assign w_run_end     = (r_cnt == TW'(RUN_LEN - 1));
   assign w_abort       = abort && (r_state != IDLE);
   assign w_accept      = (r_state == IDLE) && start;
   assign w_dp_ext      = {{(ACC_SIZE-VAL_SIZE){dp_value[VAL_SIZE-1]}}, dp_value};

   assign chunk_idx  = r_chunk;
   assign neuron_idx = r_neuron;
   assign class_out  = r_class;
   assign best_score = r_best;

   always_ff @(posedge clk or negedge GlobalReset) begin
      if (!GlobalReset) r_state <= IDLE;
      else              r_state <= w_next;
   end

   always_comb begin
      w_next   = r_state;
      dp_clear = 1'b1;
      busy     = 1'b0;
      done     = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (start) w_next = CLEAR;
         end
         CLEAR: begin
            busy   = 1'b1;
            w_next = RUN;
         end
         RUN: begin
            dp_clear = 1'b0;
            busy     = 1'b1;
            if (w_run_end) w_next = ACC;
         end
         ACC: begin
            dp_clear = 1'b0;
            busy     = 1'b1;
            w_next   = w_last_chunk ? CMP : CLEAR;
         end
         CMP: begin
            dp_clear = 1'b0;
            busy     = 1'b1;
            w_next   = w_last_neuron ? DONE : CLEAR;
         end
         DONE: begin
            done   = 1'b1;
            w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
      if (w_abort) w_next = IDLE;
   end

   always_ff @(posedge clk or negedge GlobalReset) begin
      if (!GlobalReset) begin
         r_cnt    <= '0;
         r_chunk  <= '0;
         r_neuron <= '0;
         r_acc    <= '0;
      end else if (w_abort) begin
         r_cnt    <= '0;
         r_chunk  <= '0;
         r_neuron <= '0;
         r_acc    <= '0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (start) begin
                  r_chunk  <= '0;
                  r_neuron <= '0;
                  r_acc    <= '0;
               end
            end
            CLEAR: r_cnt <= '0;
            RUN:   r_cnt <= r_cnt + TW'(1);
            ACC: begin
               r_acc <= r_acc + w_dp_ext;
               if (!w_last_chunk) r_chunk <= r_chunk + CW'(1);
            end
            CMP: begin
               r_acc   <= '0;
               r_chunk <= '0;
               if (!w_last_neuron) r_neuron <= r_neuron + NW'(1);
            end
            default: ;
         endcase
      end
   end

   // Published result only changes on completion, so an abort leaves it intact.
   always_ff @(posedge clk or negedge GlobalReset) begin
      if (!GlobalReset) begin
         r_class <= '0;
         r_best  <= '0;
      end else if (w_next == DONE && r_state == CMP) begin
         r_class <= w_class_nxt;
         r_best  <= w_best_nxt;
      end
   end

   argmax_tracker #(
      .NEURONS  (NEURONS),
      .ACC_SIZE (ACC_SIZE)
   ) u_argmax (
      .clk         (clk),
      .rst_n       (GlobalReset),
      .i_clear     (w_accept),
      .i_upd       (r_state == CMP),
      .i_acc       (r_acc),
      .i_idx       (r_neuron),
      .o_best_nxt  (w_best_nxt),
      .o_class_nxt (w_class_nxt)
   );

`ifdef NEURON_SCORE_STREAM_EN
   always_comb begin
      score_valid = (r_state == CMP);
      score       = score_valid ? r_acc : '0;
      score_idx   = score_valid ? r_neuron : '0;
   end
`endif

endmodule

// File: tb/tb_neuron_scheduler.sv
// Self-checking bench for neuron_scheduler: small-config vectors, corner sequences, default latency.
module tb_neuron_scheduler;
   import neuron_scheduler_pkg::*;

   localparam int N   = 3;
   localparam int C   = 2;
   localparam int BW  = 4;
   localparam int DR  = 2;
   localparam int VS  = 26;
   localparam int AS  = VS + 2;
   localparam int LAT = N * (C * (BW + DR + 2) + 1) + 1;
   localparam int DLAT = 10 * (4 * (196 + 12 + 2) + 1) + 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n;
   logic          start;
   logic          abort;
   logic [VS-1:0] dp_value;
   logic          dp_clear;
   logic [0:0]    chunk_idx;
   logic [1:0]    neuron_idx;
   logic          busy;
   logic          done;
   logic [1:0]    class_out;
   logic [AS-1:0] best_score;

   logic          d_start;
   logic [VS-1:0] d_dp;
   logic          d_clear;
   logic [1:0]    d_chunk;
   logic [3:0]    d_neuron;
   logic          d_busy;
   logic          d_done;
   logic [3:0]    d_class;
   logic [AS-1:0] d_best;

`ifdef NEURON_SCORE_STREAM_EN
   logic          score_valid;
   logic [AS-1:0] score;
   logic [1:0]    score_idx;
   logic          d_sv;
   logic [AS-1:0] d_score;
   logic [3:0]    d_sidx;
`endif

   logic [VS-1:0] vals [8];
   always_comb dp_value = vals[{neuron_idx, chunk_idx}];
   assign d_dp = VS'(1);

   neuron_scheduler #(
      .NEURONS(N), .CHUNKS(C), .BUS_WIDTH(BW), .DRAIN(DR), .VAL_SIZE(VS), .ACC_SIZE(AS)
   ) dut (
      .clk(clk), .GlobalReset(rst_n), .start(start), .abort(abort),
      .dp_value(dp_value), .dp_clear(dp_clear), .chunk_idx(chunk_idx),
      .neuron_idx(neuron_idx), .busy(busy), .done(done),
      .class_out(class_out), .best_score(best_score)
`ifdef NEURON_SCORE_STREAM_EN
      , .score_valid(score_valid), .score(score), .score_idx(score_idx)
`endif
   );

   neuron_scheduler dut2 (
      .clk(clk), .GlobalReset(rst_n), .start(d_start), .abort(1'b0),
      .dp_value(d_dp), .dp_clear(d_clear), .chunk_idx(d_chunk),
      .neuron_idx(d_neuron), .busy(d_busy), .done(d_done),
      .class_out(d_class), .best_score(d_best)
`ifdef NEURON_SCORE_STREAM_EN
      , .score_valid(d_sv), .score(d_score), .score_idx(d_sidx)
`endif
   );

   typedef struct {
      int     v [6];
      int     cls;
      longint best;
   } vec_t;

   typedef struct {
      int     cls;
      longint best;
   } exp_t;

   vec_t   tbl [5];
   exp_t   sbq [$];
   longint sq  [$];
   int     iq  [$];
   int     tests = 0;
   int     fails = 0;
   int     d_pulses = 0;

   task automatic chk(input string nm, input logic signed [63:0] act,
                      input logic signed [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   task automatic set_vec(input int i, input int a0, input int a1, input int a2,
                          input int a3, input int a4, input int a5,
                          input int cls, input longint best);
      tbl[i].v[0] = a0; tbl[i].v[1] = a1; tbl[i].v[2] = a2;
      tbl[i].v[3] = a3; tbl[i].v[4] = a4; tbl[i].v[5] = a5;
      tbl[i].cls  = cls;
      tbl[i].best = best;
   endtask

   task automatic load_push(input int i);
      exp_t e;
      for (int j = 0; j < 8; j++) vals[j] = '0;
      for (int j = 0; j < 6; j++) vals[j] = VS'(tbl[i].v[j]);
      e.cls  = tbl[i].cls;
      e.best = tbl[i].best;
      sbq.push_back(e);
      for (int n = 0; n < N; n++) begin
         sq.push_back(longint'(tbl[i].v[2*n]) + longint'(tbl[i].v[2*n+1]));
         iq.push_back(n);
      end
   endtask

   task automatic flush_sb();
      sbq.delete();
      sq.delete();
      iq.delete();
   endtask

   task automatic check_done(input string nm);
      exp_t e;
      if (sbq.size() == 0) begin
         tests++;
         fails++;
         $display("FAIL %s: done with no expected result queued", nm);
      end else begin
         e = sbq.pop_front();
         chk({nm, " class"}, class_out, e.cls);
         chk({nm, " best"}, $signed(best_score), e.best);
         chk({nm, " busy@done"}, busy, 0);
      end
   endtask

   task automatic run_vec(input int i, input string nm);
      int k, segs, badgap, hi;
      logic prev;
      load_push(i);
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      segs = 0; badgap = 0; hi = 0; prev = 1'b1;
      for (k = 1; k <= LAT + 20; k++) begin
         if (k > 1) @(negedge clk);
         if (done) break;
         if (!dp_clear) begin
            if (prev) begin
               segs++;
               if (segs > 1 && hi != 1) badgap++;
            end
            hi = 0;
         end else begin
            hi++;
         end
         prev = dp_clear;
      end
      chk({nm, " latency"}, k, LAT);
      if (done) check_done(nm);
      chk({nm, " run windows"}, segs, N * C);
      chk({nm, " clear gaps"}, badgap, 0);
`ifdef NEURON_SCORE_STREAM_EN
      chk({nm, " stream left"}, sq.size(), 0);
`endif
      @(negedge clk);
      chk({nm, " done pulse"}, done, 0);
      chk({nm, " class hold"}, class_out, tbl[i].cls);
   endtask

`ifdef NEURON_SCORE_STREAM_EN
   always @(negedge clk) begin
      if (score_valid) begin
         if (sq.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL score: unexpected pulse idx %0d", score_idx);
         end else begin
            chk("score", $signed(score), sq.pop_front());
            chk("score_idx", score_idx, iq.pop_front());
         end
      end
      if (d_sv) begin
         chk("d score", $signed(d_score), 4);
         chk("d score_idx", d_sidx, d_pulses);
         d_pulses++;
      end
   end
`endif

   initial begin
      int k, nd, d1, d2;
      set_vec(0, 5, 5, 5, 5, 5, 5, 0, 10);
      set_vec(1, 1, 2, 7, -3, -4, 20, 2, 16);
      set_vec(2, -4, -4, -4, -4, -4, -4, 0, -8);
      set_vec(3, -1, -1, 3, 2, 5, 0, 1, 5);
      set_vec(4, -(1 << 25), -(1 << 25), (1 << 25) - 1, (1 << 25) - 1, 0, 0,
              1, (64'sd1 << 26) - 2);
      for (int j = 0; j < 8; j++) vals[j] = '0;
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; d_start = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst busy", busy, 0);
      chk("rst done", done, 0);
      chk("rst dp_clear", dp_clear, 1);
      chk("rst class", class_out, 0);
      chk("rst best", best_score, 0);
      chk("rst neuron", neuron_idx, 0);
      chk("rst chunk", chunk_idx, 0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 5; i++) run_vec(i, $sformatf("vec%0d", i));

      // abort in neuron 1 RUN; result of vec4 must survive
      load_push(1);
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      k = 0;
      while (!(neuron_idx == 2'd1 && !dp_clear) && k < 100) begin
         @(negedge clk);
         k++;
      end
      chk("abort reach n1", k < 100, 1);
      abort = 1'b1;
      @(negedge clk) abort = 1'b0;
      chk("abort busy", busy, 0);
      chk("abort dp_clear", dp_clear, 1);
      chk("abort done", done, 0);
      chk("abort class", class_out, tbl[4].cls);
      chk("abort best", $signed(best_score), tbl[4].best);
      flush_sb();
      nd = 0;
      repeat (LAT + 10) begin
         @(negedge clk);
         if (done) nd++;
      end
      chk("abort no done", nd, 0);
      run_vec(1, "post-abort");

      // start held high across two runs
      load_push(0);
      load_push(2);
      sbq.delete();
      sbq.push_back('{tbl[2].cls, tbl[2].best});
      sbq.push_back('{tbl[2].cls, tbl[2].best});
      sq.delete(); iq.delete();
      for (int r = 0; r < 2; r++)
         for (int n = 0; n < N; n++) begin
            sq.push_back(-8);
            iq.push_back(n);
         end
      nd = 0; d1 = 0; d2 = 0;
      @(negedge clk) start = 1'b1;
      for (int kk = 1; kk <= 2 * LAT + 2; kk++) begin
         @(negedge clk);
         if (done) begin
            nd++;
            if (nd == 1) d1 = kk;
            else d2 = kk;
            check_done($sformatf("held%0d", nd));
         end
         if (kk == LAT + 1) chk("held idle after done", busy, 0);
      end
      start = 1'b0;
      chk("held done count", nd, 2);
      chk("held first done", d1, LAT);
      chk("held second done", d2, 2 * LAT + 1);
      repeat (3) @(negedge clk);
      chk("held stops", busy, 0);
      flush_sb();

      // asynchronous reset in the middle of RUN
      load_push(1);
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      repeat (3) @(negedge clk);
      chk("pre-rst busy", busy, 1);
      #1 rst_n = 1'b0;
      #1;
      chk("mid-rst busy", busy, 0);
      chk("mid-rst dp_clear", dp_clear, 1);
      chk("mid-rst class", class_out, 0);
      chk("mid-rst best", best_score, 0);
      chk("mid-rst done", done, 0);
      flush_sb();
      @(negedge clk) rst_n = 1'b1;
      @(negedge clk);

      // default parameters, dp_value 1 everywhere
      d_pulses = 0;
      @(negedge clk) d_start = 1'b1;
      @(negedge clk) d_start = 1'b0;
      for (k = 1; k <= DLAT + 50; k++) begin
         if (k > 1) @(negedge clk);
         if (d_done) break;
      end
      chk("default latency", k, DLAT);
      chk("default class", d_class, 0);
      chk("default best", $signed(d_best), 4);
`ifdef NEURON_SCORE_STREAM_EN
      chk("default pulses", d_pulses, 10);
`endif
      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
